arb_request_agent: RTL
======================

// Module: arb_request_agent
// PURPOSE
//  Requester-side bank for the fixed-priority r/g grant interface: N client channels, each
//  accepts a job (beat count), raises r[i], waits for the registered grant g[i], issues beats
//  while granted, then releases. Sits between client logic and the 8-way priority arbiter
//  (index 0 = highest priority); detects lost grants (preemption) and optionally starvation.
// PARAMETERS
//  N            8    number of client channels; r/g width
//  LEN_W        4    job length field width; beats per job = job_len+1 (1..2**LEN_W)
//  STARVE_LIMIT 64   cycles in REQ without grant before starve[i] asserts (STARVE_DETECT_EN only)
// PORTS
//  clock       in   1          clock; all state updates on posedge
//  reset       in   1          synchronous, active-high
//  job_valid   in   [0:N-1]    client i offers a job
//  job_len     in   [N][LEN_W] beat count minus one, per client
//  job_ready   out  [0:N-1]    channel i idle and accepting; job taken when valid&ready
//  r           out  [0:N-1]    request vector to arbiter
//  g           in   [0:N-1]    grant vector from arbiter (registered, one cycle after r)
//  beat_valid  out  [0:N-1]    channel i transfers one beat this cycle
//  done        out  [0:N-1]    one-cycle pulse on the last beat of channel i's job
//  preempt_err out  [0:N-1]    one-cycle pulse: grant lost mid-job on channel i
//  starve      out  [0:N-1]    sticky starvation flag (0 constant when macro absent)
// BEHAVIOUR
//  - Per-channel FSM: IDLE, REQ, XFER, REL. Reset: all channels IDLE, remaining count 0,
//    r=0, job_ready=all 1, beat_valid/done/preempt_err/starve=0.
//  - IDLE: job_ready[i]=1. On job_valid[i]: capture rem=job_len[i]; -> REQ next cycle.
//  - REQ: r[i]=1. If g[i]=1: beat this cycle, -> XFER (or REL if rem==0). Else stay.
//  - XFER: r[i]=1, beat_valid[i]=g[i]. g[i]=1: rem decrements; on rem==0 beat, done[i]=1,
//    -> REL. g[i]=0: preempt_err[i]=1 for one cycle, no beat, rem kept, -> REQ.
//  - REL: r[i]=0, one cycle only; g[i] ignored (arbiter grant lags r by one cycle); -> IDLE.
//  - r, job_ready, beat_valid, done, preempt_err are decoded from current state plus g;
//    beat_valid[i] = g[i] & (state in REQ/XFER). Never beat when r[i]=0.
//  - Single-beat job (job_len=0): IDLE->REQ->(granted) beat+done->REL->IDLE; 4 cycles minimum
//    job-to-job from one channel.
//  - Simultaneous requests: channels independent; arbiter resolves, lower-priority channels
//    wait in REQ. Grant to a channel not requesting is ignored (no beat, no error).
//  - Reset mid-job: job discarded, no done pulse, all channels IDLE next cycle.
//  - rem width LEN_W, counts down, never wraps below 0 (XFER exits at 0).
// CONFIGURATION
//  STARVE_DETECT_EN defined: per-channel wait counter, cleared on entry to REQ, increments
//   each REQ cycle without g[i], saturates at STARVE_LIMIT; starve[i] sets when counter
//   reaches STARVE_LIMIT, clears only on next beat of channel i or reset.
//  STARVE_DETECT_EN undefined: no counters instantiated; starve tied to 0.
// STRUCTURE
//  - Package arb_pkg: typedef enum logic [1:0] {IDLE, REQ, XFER, REL} req_state_t;
//    localparam ARB_N = 8; shared with arbiter-side benches.
//  - Sub-module arb_req_cell: one channel (FSM, rem counter, optional wait counter);
//    top generates N cells and concatenates r/beat_valid/done/preempt_err/starve.
// TESTING (bench wires r/g to the 8-way registered priority arbiter)
//  1 Reset: hold reset 3 cycles, job_valid=8'hFF -> r=0, job_ready=8'hFF, all pulses 0.
//  2 Single job ch3 len=2: r[3] rises, g[3] next cycle, 3 beat_valid pulses, done on 3rd,
//    r[3] low in REL, job_ready[3] high 1 cycle later.
//  3 Contention: ch5 len=3 and ch1 len=1 same cycle -> ch1 2 beats + done, then ch5 4 beats;
//    no beat on ch5 until ch1 in REL.
//  4 Preemption: ch6 in XFER rem=5, start ch0 len=0 -> preempt_err[6] pulse when g[6] drops,
//    ch6 back to REQ, completes remaining beats after ch0; total ch6 beats = job_len+1.
//  5 Reset mid-XFER on ch2 -> no done[2], r=0 next cycle, job_ready[2]=1.
//  6 STARVE_DETECT_EN, STARVE_LIMIT=8: ch0 continuous len=15 jobs, ch7 requesting ->
//    starve[7]=1 after 8 waiting cycles, clears on ch7's first beat; macro off -> starve=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the r/g request/grant fabric: channel FSM encoding and bank width.
// Used by the requester bank and by arbiter-side benches.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } req_state_t;

  localparam int ARB_N     = 8;
  localparam int ARB_LEN_W = 4;

  // A channel drives r (and may beat) only while waiting for or holding a grant.
  function automatic logic req_active(input req_state_t s);
    return (s == REQ) || (s == XFER);
  endfunction

endpackage

// File: rtl/arb_request_agent_if.sv
// Bundle of client job handshake and arbiter r/g signals for the requester bank.
// slave = requester bank side, master = client/arbiter side.
interface arb_request_agent_if
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int LEN_W = ARB_LEN_W
);

  logic [0:N-1]              job_valid;
  logic [0:N-1][LEN_W-1:0]   job_len;
  logic [0:N-1]              job_ready;
  logic [0:N-1]              r;
  logic [0:N-1]              g;
  logic [0:N-1]              beat_valid;
  logic [0:N-1]              done;
  logic [0:N-1]              preempt_err;
  logic [0:N-1]              starve;

  modport slave (
    input  job_valid, job_len, g,
    output job_ready, r, beat_valid, done, preempt_err, starve
  );

  modport master (
    output job_valid, job_len, g,
    input  job_ready, r, beat_valid, done, preempt_err, starve
  );

endinterface

// File: rtl/arb_req_cell.sv
// One requester channel: IDLE/REQ/XFER/REL FSM with a remaining-beat counter.
// Optional starvation watchdog compiled in with STARVE_DETECT_EN.
module arb_req_cell
  import arb_pkg::*;
#(
  parameter int LEN_W        = ARB_LEN_W,
  parameter int STARVE_LIMIT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  input  logic             g,
  output logic             job_ready,
  output logic             r,
  output logic             beat_valid,
  output logic             done,
  output logic             preempt_err,
  output logic             starve
);

  localparam logic [LEN_W-1:0] REM_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] REM_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  req_state_t       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  // Next-state and decoded outputs; a grant outside REQ/XFER is ignored.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    job_ready   = 1'b0;
    r           = req_active(state_q);
    beat_valid  = 1'b0;
    done        = 1'b0;
    preempt_err = 1'b0;
    case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          rem_d   = job_len;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ, XFER: begin
        if (g) begin
          beat_valid = 1'b1;
          if (rem_q == REM_ZERO) begin
            done    = 1'b1;
            state_d = REL;
          end else begin
            rem_d   = rem_q - REM_ONE;
            state_d = XFER;
          end
        end else if (state_q == XFER) begin
          // Grant taken away mid-job: keep rem and re-request.
          preempt_err = 1'b1;
          state_d     = REQ;
        end else begin
          state_d = REQ;
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Channel state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= REM_ZERO;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef STARVE_DETECT_EN
  localparam int                WAIT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starve_q, starve_d;

  // Wait counter restarts on every entry to REQ; flag is sticky until a beat.
  always_comb begin
    wait_d   = wait_q;
    starve_d = starve_q;
    if ((state_d == REQ) && (state_q != REQ)) begin
      wait_d = {WAIT_W{1'b0}};
    end else if ((state_q == REQ) && !g && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WAIT_ONE;
    end else begin
      wait_d = wait_q;
    end
    if (beat_valid) begin
      starve_d = 1'b0;
    end else if ((state_q == REQ) && (wait_d == WAIT_MAX)) begin
      starve_d = 1'b1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation watchdog registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q   <= {WAIT_W{1'b0}};
      starve_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: rtl/arb_request_agent.sv
// Requester-side bank of N independent channels for the fixed-priority r/g arbiter.
// Define STARVE_DETECT_EN to build the per-channel starvation watchdog.
module arb_request_agent
  import arb_pkg::*;
#(
  parameter int N            = ARB_N,
  parameter int LEN_W        = ARB_LEN_W,
  parameter int STARVE_LIMIT = 64
) (
  input  logic           clock,
  input  logic           reset,
  arb_request_agent_if.slave bus
);

  logic [0:N-1] job_ready_v;
  logic [0:N-1] r_v;
  logic [0:N-1] beat_valid_v;
  logic [0:N-1] done_v;
  logic [0:N-1] preempt_err_v;
  logic [0:N-1] starve_v;

  for (genvar i = 0; i < N; i++) begin : g_cell
    arb_req_cell #(
      .LEN_W        (LEN_W),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_cell (
      .clock       (clock),
      .reset       (reset),
      .job_valid   (bus.job_valid[i]),
      .job_len     (bus.job_len[i]),
      .g           (bus.g[i]),
      .job_ready   (job_ready_v[i]),
      .r           (r_v[i]),
      .beat_valid  (beat_valid_v[i]),
      .done        (done_v[i]),
      .preempt_err (preempt_err_v[i]),
      .starve      (starve_v[i])
    );
  end

  assign bus.job_ready   = job_ready_v;
  assign bus.r           = r_v;
  assign bus.beat_valid  = beat_valid_v;
  assign bus.done        = done_v;
  assign bus.preempt_err = preempt_err_v;
  assign bus.starve      = starve_v;

endmodule
